// File: rtl/srl_dly_nxw.sv
// srl_dly_nxw: addressable shift-register delay line with fill tracking and optional output register
module srl_dly_nxw #(
  parameter int WIDTH = 1,
  parameter int AW    = 4,
  parameter int OREG  = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             CLR,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] QLAST,
  output logic             VALID
);
  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  logic [WIDTH-1:0] stg_q [DEPTH];
  logic [AW:0]      f_q;
  logic [WIDTH-1:0] tap_d, last_d;
  logic             vld_d;
  // shift chain: flush wins over shift, hold otherwise
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      for (int n = 0; n < DEPTH; n++) stg_q[n] <= '0;
    end else if (CLR) begin
      for (int n = 0; n < DEPTH; n++) stg_q[n] <= '0;
    end else if (CE) begin
      stg_q[0] <= I;
      for (int n = 1; n < DEPTH; n++) stg_q[n] <= stg_q[n-1];
    end
  // fill count saturates at DEPTH so VALID stays high once the line is full
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) f_q <= '0;
    else if (CLR) f_q <= '0;
    else if (CE && f_q != FULL) f_q <= f_q + (AW+1)'(1);
  // tap selection and validity against the current address
  always_comb begin
    tap_d  = stg_q[A];
    last_d = stg_q[DEPTH-1];
    vld_d  = f_q > {1'b0, A};
  end
  if (OREG != 0) begin : g_reg
    logic [WIDTH-1:0] o_q, last_q;
    logic             vld_q;
    // output register runs every edge regardless of CE; flush zeroes it
    always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
        o_q    <= '0;
        last_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        o_q    <= CLR ? '0 : tap_d;
        last_q <= CLR ? '0 : last_d;
        vld_q  <= CLR ? 1'b0 : vld_d;
      end
    assign O     = o_q;
    assign QLAST = last_q;
    assign VALID = vld_q;
  end else begin : g_comb
    assign O     = tap_d;
    assign QLAST = last_d;
    assign VALID = vld_d;
  end
endmodule
